// File: rtl/ez8_mem_pkg.sv
// ---------------------------------------------------------------------------
// ez8_mem_pkg
// Shared definitions for the data-memory port arbiter:
//   - ADDR_W / DATA_W : 8-bit address and data widths of the memory port
//   - GP_BASE_DEFAULT : lowest general-purpose address; everything below is
//                       status/bank/interrupt registers that DMA must not touch
//   - arb_state_t     : arbiter ownership state (IDLE, DMA, DRAIN)
// ---------------------------------------------------------------------------
package ez8_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] GP_BASE_DEFAULT = 8'h10;

  // IDLE  : CPU owns the memory port
  // DMA   : DMA burst in progress, CPU stalled
  // DRAIN : one hand-back cycle so the CPU read address is re-presented
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DMA   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single data-memory read/write port between the CPU pipeline and
// one DMA-style requester. The CPU owns the port by default; DMA gets bounded
// bursts of at most MAX_BURST accesses, separated by at least CPU_SLOT
// CPU-owned cycles. The CPU is stalled during a burst, and the read data for
// the CPU's last pre-burst read is held until the CPU resumes.
//
// Parameters:
//   MAX_BURST : max consecutive DMA accesses per grant (1..255)
//   CPU_SLOT  : min CPU-owned cycles between bursts (0..255)
//   GP_BASE   : lowest address DMA may touch
//
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   cpu_readaddr/writeaddr/
//   cpu_writedata/cpu_write_en    : CPU side memory request
//   cpu_readdata, cpu_stall       : CPU read return and stall
//   dma_req/addr/wdata/we         : DMA request, held until accepted
//   dma_gnt                       : access accepted when dma_req && dma_gnt
//   dma_rvalid, dma_rdata         : DMA read return, one cycle after accept
//   dma_err                       : access below GP_BASE (dropped), rvalid timing
//   mem_readaddr/writeaddr/
//   mem_writedata/mem_write_en    : to memory controller
//   mem_readdata                  : from memory controller, 1-cycle latency
//   stall_cycles                  : saturating stall-cycle counter, present
//                                   only when MEM_ARB_STALL_CNT_EN is defined
// ---------------------------------------------------------------------------
module mem_arbiter
  import ez8_mem_pkg::*;
#(
  parameter int unsigned       MAX_BURST = 8,
  parameter int unsigned       CPU_SLOT  = 2,
  parameter logic [ADDR_W-1:0] GP_BASE   = GP_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_readaddr,
  input  logic [ADDR_W-1:0] cpu_writeaddr,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic              cpu_write_en,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_we,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic [ADDR_W-1:0] mem_readaddr,
  output logic [ADDR_W-1:0] mem_writeaddr,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_write_en,
`ifdef MEM_ARB_STALL_CNT_EN
  output logic [15:0]       stall_cycles,
`endif
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [7:0] SLOT_MIN   = 8'(CPU_SLOT);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  arb_state_t        state;
  logic [7:0]        slot_cnt;
  logic [7:0]        burst_cnt;
  logic [DATA_W-1:0] hold;
  logic              hold_valid;
  logic              first_dma;
  logic              rvalid_q;
  logic              err_q;

  logic accept;
  logic dma_low;

  assign accept  = (state == DMA) && dma_req;
  assign dma_low = (dma_addr < GP_BASE);

  assign cpu_stall    = (state != IDLE);
  assign dma_gnt      = (state == DMA);
  assign dma_rvalid   = rvalid_q;
  assign dma_err      = err_q;
  // Protected-region reads return zero so register contents never leak to DMA.
  assign dma_rdata    = (rvalid_q && !err_q) ? mem_readdata : '0;
  assign cpu_readdata = hold_valid ? hold : mem_readdata;

  // Memory port mux. CPU addresses are the default so DRAIN re-presents the
  // CPU read address; only an accepted, in-range DMA write may reach memory.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    mem_readaddr  = cpu_readaddr;
    mem_writeaddr = cpu_writeaddr;
    mem_writedata = cpu_writedata;
    mem_write_en  = 1'b0;
    case (state)
      IDLE: mem_write_en = cpu_write_en;
      DMA: begin
        mem_readaddr  = dma_addr;
        mem_writeaddr = dma_addr;
        mem_writedata = dma_wdata;
        mem_write_en  = accept && dma_we && !dma_low;
      end
      default: mem_write_en = 1'b0;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      slot_cnt   <= '0;
      burst_cnt  <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      first_dma  <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rvalid_q  <= accept && !dma_we;
      err_q     <= accept && dma_low;
      first_dma <= 1'b0;
      case (state)
        IDLE: begin
          if (slot_cnt != 8'hFF) slot_cnt <= slot_cnt + 8'd1;
          // Held data is only needed through the first cycle back in IDLE.
          hold_valid <= 1'b0;
          if (dma_req && (slot_cnt >= SLOT_MIN)) begin
            state     <= DMA;
            burst_cnt <= '0;
            first_dma <= 1'b1;
          end
        end
        DMA: begin
          // The read issued in the last IDLE cycle returns now; keep it for the CPU.
          if (first_dma) begin
            hold       <= mem_readdata;
            hold_valid <= 1'b1;
          end
          if (accept) burst_cnt <= burst_cnt + 8'd1;
          // In DMA, accept == dma_req, so the count limit only triggers on an accept.
          if (!dma_req || (burst_cnt == BURST_LAST)) state <= DRAIN;
        end
        DRAIN: begin
          state    <= IDLE;
          slot_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (cpu_stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Drives mem_arbiter with directed scenarios and then randomized CPU/DMA
// traffic. A 256-byte memory with one-cycle read latency stands in for the
// memory controller. An ownership-level reference model predicts every
// output each cycle; directed scenarios pin specific literal values.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int         MAX_BURST = 8;
  localparam int         CPU_SLOT  = 2;
  localparam logic [7:0] GP_BASE   = 8'h10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cpu_readaddr = '0;
  logic [7:0] cpu_writeaddr = '0;
  logic [7:0] cpu_writedata = '0;
  logic       cpu_write_en = 1'b0;
  logic [7:0] cpu_readdata;
  logic       cpu_stall;
  logic       dma_req = 1'b0;
  logic [7:0] dma_addr = '0;
  logic [7:0] dma_wdata = '0;
  logic       dma_we = 1'b0;
  logic       dma_gnt;
  logic       dma_rvalid;
  logic [7:0] dma_rdata;
  logic       dma_err;
  logic [7:0] mem_readaddr;
  logic [7:0] mem_writeaddr;
  logic [7:0] mem_writedata;
  logic       mem_write_en;
  logic [7:0] mem_readdata;
`ifdef MEM_ARB_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int tests = 0;
  int fails = 0;

  mem_arbiter #(
    .MAX_BURST(MAX_BURST),
    .CPU_SLOT (CPU_SLOT),
    .GP_BASE  (GP_BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_readaddr (cpu_readaddr),
    .cpu_writeaddr(cpu_writeaddr),
    .cpu_writedata(cpu_writedata),
    .cpu_write_en (cpu_write_en),
    .cpu_readdata (cpu_readdata),
    .cpu_stall    (cpu_stall),
    .dma_req      (dma_req),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .dma_we       (dma_we),
    .dma_gnt      (dma_gnt),
    .dma_rvalid   (dma_rvalid),
    .dma_rdata    (dma_rdata),
    .dma_err      (dma_err),
    .mem_readaddr (mem_readaddr),
    .mem_writeaddr(mem_writeaddr),
    .mem_writedata(mem_writedata),
    .mem_write_en (mem_write_en),
`ifdef MEM_ARB_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .mem_readdata (mem_readdata)
  );

  always #5 clk = ~clk;

  // Memory controller stand-in: read data one cycle after the address,
  // a read of an address written in the same cycle returns the old value.
  logic [7:0] mem [256];
  logic       mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
      mem[8'h30] <= 8'hA5;
      mem[8'h40] <= 8'h00;
      mem[8'h01] <= 8'h3C;
      mem_init_done <= 1'b1;
    end else if (mem_write_en) begin
      mem[mem_writeaddr] <= mem_writedata;
    end
    mem_readdata <= mem[mem_readaddr];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Who owns the port: 0 = CPU, 1 = DMA burst, 2 = hand-back cycle.
  int         m_owner;
  int         m_idle_run;     // CPU-owned cycles since the last hand-back
  int         m_burst_done;   // DMA accesses taken in the current burst
  bit         m_rv, m_err;
  logic [7:0] m_rd_val;
  logic [7:0] m_last_cpu;     // data of the CPU's most recent own read
  bit         m_have_cpu;
  bit         m_valid = 1'b0;
  bit         m_acc;

  always @(posedge clk) begin
    if (reset) begin
      m_owner = 0; m_idle_run = 0; m_burst_done = 0;
      m_rv = 0; m_err = 0; m_have_cpu = 0; m_valid = 1;
    end else if (m_valid) begin
      m_acc    = (m_owner == 1) && dma_req;
      m_rv     = m_acc && !dma_we;
      m_err    = m_acc && (dma_addr < GP_BASE);
      m_rd_val = (dma_addr < GP_BASE) ? 8'h00 : mem[dma_addr];
      if (m_owner == 0) begin
        m_last_cpu = mem[cpu_readaddr];
        m_have_cpu = 1;
        if (dma_req && m_idle_run >= CPU_SLOT) begin
          m_owner = 1;
          m_burst_done = 0;
        end
        if (m_idle_run < 255) m_idle_run++;
      end else if (m_owner == 1) begin
        if (m_acc) m_burst_done++;
        if (!dma_req || m_burst_done == MAX_BURST) m_owner = 2;
      end else begin
        m_owner = 0;
        m_idle_run = 0;
      end
    end
  end

  bit c_acc, c_we;
  always @(negedge clk) begin
    if (m_valid && !reset) begin
      c_acc = (m_owner == 1) && dma_req;
      c_we  = (m_owner == 0) ? cpu_write_en : (c_acc && dma_we && dma_addr >= GP_BASE);
      check("cpu_stall", cpu_stall, m_owner != 0);
      check("dma_gnt", dma_gnt, m_owner == 1);
      check("mem_write_en", mem_write_en, c_we);
      if (m_owner != 1) check("mem_readaddr", mem_readaddr, cpu_readaddr);
      else if (c_acc) check("mem_readaddr_dma", mem_readaddr, dma_addr);
      if (c_we) begin
        check("mem_writeaddr", mem_writeaddr, (m_owner == 0) ? cpu_writeaddr : dma_addr);
        check("mem_writedata", mem_writedata, (m_owner == 0) ? cpu_writedata : dma_wdata);
      end
      check("dma_rvalid", dma_rvalid, m_rv);
      check("dma_err", dma_err, m_err);
      if (m_rv) check("dma_rdata", dma_rdata, m_rd_val);
      if (m_have_cpu) check("cpu_readdata", cpu_readdata, m_last_cpu);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 40 && cpu_stall; c++) cyc();
    check("wait_idle", cpu_stall, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit a, got, stl;
  int n_acc, seg, b1, b2, gap;

  initial begin
    // Reset state
    reset = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    check("rst_gnt", dma_gnt, 1'b0);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_rvalid", dma_rvalid, 1'b0);
    check("rst_err", dma_err, 1'b0);

    // 1: CPU reads 0x20, 0x21 with no DMA
    cyc(); reset = 1'b0; cpu_readaddr = 8'h20;
    @(negedge clk);
    check("t1_raddr20", mem_readaddr, 8'h20);
    check("t1_stall", cpu_stall, 1'b0);
    check("t1_gnt", dma_gnt, 1'b0);
    cyc(); cpu_readaddr = 8'h21;
    @(negedge clk);
    check("t1_raddr21", mem_readaddr, 8'h21);
    check("t1_stall2", cpu_stall, 1'b0);

    // 2+3: CPU reads 0x30 as DMA asks; DMA writes 0x40=0x5A then reads it
    cyc();
    cpu_readaddr = 8'h30;
    dma_req = 1'b1; dma_addr = 8'h40; dma_we = 1'b1; dma_wdata = 8'h5A;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (dma_gnt) got = 1; else cyc();
    end
    check("t2_granted", got, 1'b1);
    check("t2_stall", cpu_stall, 1'b1);
    check("t2_hold_dma1", cpu_readdata, 8'hA5);
    check("t3_wr_en", mem_write_en, 1'b1);
    check("t3_waddr", mem_writeaddr, 8'h40);
    check("t3_wdata", mem_writedata, 8'h5A);
    cyc(); dma_we = 1'b0;
    @(negedge clk);
    check("t2_hold_dma2", cpu_readdata, 8'hA5);
    check("t3_no_rvalid_wr", dma_rvalid, 1'b0);
    cyc(); dma_req = 1'b0;
    @(negedge clk);
    check("t3_rvalid", dma_rvalid, 1'b1);
    check("t3_rdata", dma_rdata, 8'h5A);
    check("t2_hold_dma3", cpu_readdata, 8'hA5);
    cyc();
    @(negedge clk);
    check("t2_drain_stall", cpu_stall, 1'b1);
    check("t2_drain_gnt", dma_gnt, 1'b0);
    check("t2_drain_raddr", mem_readaddr, 8'h30);
    check("t2_hold_drain", cpu_readdata, 8'hA5);
    cyc();
    @(negedge clk);
    check("t2_idle_stall", cpu_stall, 1'b0);
    check("t2_hold_idle", cpu_readdata, 8'hA5);

    // 4: 12 requested accesses split into 8 + 4 around a CPU slot
    dma_addr = 8'h50; dma_we = 1'b0; dma_req = 1'b1;
    n_acc = 0; seg = 0; b1 = 0; b2 = 0; gap = 0;
    for (int c = 0; c < 80 && n_acc < 12; c++) begin
      @(negedge clk);
      a = dma_req && dma_gnt;
      if (seg == 0 && a) b1++;
      else if (seg == 0 && b1 > 0 && cpu_stall && !dma_gnt) seg = 1;
      else if (seg == 1 && !cpu_stall) gap++;
      if (seg == 1 && a) seg = 2;
      if (seg == 2 && a) b2++;
      cyc();
      if (a) begin
        n_acc++;
        dma_addr = dma_addr + 8'd1;
        if (n_acc == 12) dma_req = 1'b0;
      end
    end
    check("t4_total", 16'(n_acc), 16'd12);
    check("t4_burst1", 16'(b1), 16'd8);
    check("t4_gap_ge2", gap >= 2, 1'b1);
    check("t4_burst2", 16'(b2), 16'd4);
    repeat (4) cyc();

    // 5: DMA write into the protected region is dropped and flagged
    wait_idle();
    dma_addr = 8'h01; dma_wdata = 8'hFF; dma_we = 1'b1; dma_req = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (dma_gnt) begin
        got = 1;
        check("t5_wr_en", mem_write_en, 1'b0);
      end
      cyc();
    end
    dma_req = 1'b0;
    check("t5_accepted", got, 1'b1);
    @(negedge clk);
    check("t5_err", dma_err, 1'b1);
    check("t5_no_rvalid", dma_rvalid, 1'b0);
    cyc();
    @(negedge clk);
    check("t5_err_pulse", dma_err, 1'b0);
    check("t5_status", mem[8'h01], 8'h3C);
    repeat (3) cyc();

    // 6: reset during the third access of a burst
    wait_idle();
    dma_addr = 8'h60; dma_we = 1'b0; dma_req = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 20 && n_acc < 2; c++) begin
      @(negedge clk);
      a = dma_req && dma_gnt;
      cyc();
      if (a) begin
        n_acc++;
        dma_addr = dma_addr + 8'd1;
      end
    end
    reset = 1'b1;
    @(negedge clk);
    check("t6_third_gnt", dma_gnt, 1'b1);
    cyc(); reset = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    check("t6_stall", cpu_stall, 1'b0);
    check("t6_gnt", dma_gnt, 1'b0);
    check("t6_rvalid", dma_rvalid, 1'b0);
    check("t6_err", dma_err, 1'b0);
    cyc();
    @(negedge clk);
    check("t6_rvalid2", dma_rvalid, 1'b0);

    // Randomized traffic against the model, with one reset pulse mid-run
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a = dma_req && dma_gnt;
      stl = cpu_stall;
      cyc();
      reset = (c == 1500);
      if (a || !dma_req) begin
        dma_req   = ($urandom_range(0, 9) < 7);
        dma_addr  = 8'($urandom);
        dma_we    = 1'($urandom_range(0, 1));
        dma_wdata = 8'($urandom);
      end
      if (!stl) begin
        cpu_readaddr  = 8'($urandom);
        cpu_writeaddr = 8'($urandom);
        cpu_writedata = 8'($urandom);
        cpu_write_en  = ($urandom_range(0, 3) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
